// File: rtl/if_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: FSM encoding, fetch exception
// codes and the queue entry layout.
package if_fetch_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [8:0] EXC_NONE   = 9'h000;
    localparam logic [8:0] EXC_ADEL_F = 9'h002;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [8:0]  exc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// fetch_fifo: DEPTH-entry synchronous queue of fetch entries with a
// synchronous clear, async reset and an occupancy count.
module fetch_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] PCBASE = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign rdata = mem[rptr];

    // When full, push and pop may coincide: the head is read before the
    // slot it occupies is overwritten at the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: PCBASE, instr: 32'h0, exc: EXC_NONE};
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !clr && count == (PW+1)'(DEPTH)));

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues one outstanding imem request at a time and
// queues responses for decode. Optional same-cycle bypass: define FETCH_BYPASS_EN.
`ifndef PCBASE
`define PCBASE 32'hBFC0_0000
`endif

module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] PCBASE = `PCBASE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc,
    output logic                     installF,
    input  logic                     flush,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [31:0]              d_pc,
    output logic [31:0]              d_instr,
    output logic [8:0]               d_exc,
    output fetch_state_t             dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_state_t  state;
    logic [31:0]   lpc;
    logic [PW:0]   count;
    logic [PW+1:0] used;
    fetch_entry_t  head;
    fetch_entry_t  wdata;
    logic          fifo_push;
    logic          fifo_pop;
    logic          space;
    logic          aligned;
    logic          resp;
    logic          mis_push;
    logic          bypass;

    // Handshakes: imem transfers a request when imem_req && imem_gnt, and a
    // response on imem_rvalid (no back-pressure); decode takes the head when
    // d_valid && d_ready. A valid never depends on its own ready.
    always_comb begin
        fifo_pop = (count != '0) && d_ready;
        // An outstanding request (WAIT or DROP) reserves one queue slot.
        used     = {1'b0, count} + (PW+2)'(state != ST_IDLE) - (PW+2)'(fifo_pop);
        space    = used < (PW+2)'(DEPTH);
        aligned  = (pc[1:0] == 2'b00);
        resp     = (state == ST_WAIT) && imem_rvalid && !flush;
`ifdef FETCH_BYPASS_EN
        bypass   = resp && (count == '0);
`else
        bypass   = 1'b0;
`endif
        imem_req = 1'b0;
        mis_push = 1'b0;
        if (!rst && !flush) begin
            if (state == ST_IDLE || resp) begin
                imem_req = space && aligned;
            end
            if (state == ST_IDLE) begin
                mis_push = space && !aligned;
            end
        end
        imem_addr = imem_req ? pc : 32'h0;
        fifo_push = mis_push || (resp && !(bypass && d_ready));
        if (mis_push) begin
            wdata = '{pc: pc, instr: 32'h0, exc: EXC_ADEL_F};
        end else begin
            wdata = '{pc: lpc, instr: imem_rdata, exc: EXC_NONE};
        end
        if (rst) begin
            installF = 1'b1;
        end else if (flush) begin
            installF = 1'b0;
        end else begin
            installF = !((imem_req && imem_gnt) || mis_push);
        end
        d_valid = (count != '0) || bypass;
        if (bypass) begin
            {d_pc, d_instr, d_exc} = {lpc, imem_rdata, EXC_NONE};
        end else begin
            {d_pc, d_instr, d_exc} = head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            lpc   <= PCBASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        state <= ST_WAIT;
                        lpc   <= pc;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state <= imem_rvalid ? ST_IDLE : ST_DROP;
                    end else if (imem_rvalid) begin
                        if (imem_req && imem_gnt) begin
                            lpc <= pc;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    // The discarded response retires the stale request.
                    if (imem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .PCBASE (PCBASE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .wdata (wdata),
        .pop   (fifo_pop),
        .rdata (head),
        .count (count)
    );

    assign dbg_state = state;
    assign dbg_count = count;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_fetch_buffer;
  import if_fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] TB_PCBASE = 32'h8000_0000;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  pc = '0;
  logic         installF;
  logic         flush = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         d_valid;
  logic         d_ready = 1'b0;
  logic [31:0]  d_pc;
  logic [31:0]  d_instr;
  logic [8:0]   d_exc;
  fetch_state_t dbg_state;
  logic [2:0]   dbg_count;

  if_fetch_buffer #(.DEPTH(DEPTH), .PCBASE(TB_PCBASE)) dut (
    .clk(clk), .rst(rst), .pc(pc), .installF(installF), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_instr(d_instr),
    .d_exc(d_exc), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  int total = 0;
  int bad = 0;

  // scoreboard: expected queue contents {pc, instr, exc}
  logic [72:0] exp_q[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_pc;

  // memory responder
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;

  // stimulus knobs
  logic [31:0] pc_reg;
  bit          auto_pc;
  bit          rnd_mode;
  bit          s_flush, s_gnt, s_ready;
  logic [31:0] s_target, s_data;
  int          s_lat;
  bit          seen_dead;

  // observations from the last step
  logic        obs_req, obs_stall, obs_dvalid;
  logic [31:0] obs_addr, obs_dpc, obs_dinstr;
  logic [8:0]  obs_exc;
  logic [31:0] obs_count, obs_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    bit e_pop, space, aligned, resp, byp, e_req, e_mis, e_stall, e_dv, rv;
    int used;
    logic [72:0] head;
    logic [31:0] tmp;
    fetch_state_t es;
    @(negedge clk);
    rv = mem_busy && (mem_cnt == 1);
    pc = pc_reg; flush = s_flush; imem_gnt = s_gnt; d_ready = s_ready;
    imem_rvalid = rv;
    imem_rdata = rv ? mem_data : $urandom;
    #1;
    aligned = (pc_reg[1:0] == 2'b00);
    e_pop = (exp_q.size() != 0) && s_ready;
    used = exp_q.size() + int'(m_out) - int'(e_pop);
    space = used < DEPTH;
    resp = m_out && !m_drop && rv && !s_flush;
`ifdef FETCH_BYPASS_EN
    byp = resp && (exp_q.size() == 0);
`else
    byp = 1'b0;
`endif
    e_req = 1'b0; e_mis = 1'b0;
    if (s_flush) e_stall = 1'b0;
    else if (m_drop) e_stall = 1'b1;
    else begin
      e_req = (!m_out || rv) && space && aligned;
      e_mis = !m_out && space && !aligned;
      e_stall = !((e_req && s_gnt) || e_mis);
    end
    e_dv = (exp_q.size() != 0) || byp;
    head = byp ? {m_pc, mem_data, EXC_NONE} : ((exp_q.size() != 0) ? exp_q[0] : 73'h0);
    es = m_drop ? ST_DROP : (m_out ? ST_WAIT : ST_IDLE);

    obs_req = imem_req; obs_stall = installF; obs_dvalid = d_valid;
    obs_addr = imem_addr; obs_dpc = d_pc; obs_dinstr = d_instr; obs_exc = d_exc;
    obs_count = 32'(dbg_count); obs_state = 32'(dbg_state);

    chk("installF", 32'(installF), 32'(e_stall));
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, pc_reg);
    chk("d_valid", 32'(d_valid), 32'(e_dv));
    if (e_dv) begin
      chk("d_pc", d_pc, head[72:41]);
      chk("d_instr", d_instr, head[40:9]);
      chk("d_exc", 32'(d_exc), 32'(head[8:0]));
    end
    chk("count", obs_count, 32'(exp_q.size()));
    chk("state", obs_state, 32'(es));
    if (d_valid && d_instr == 32'hDEADBEEF) seen_dead = 1'b1;

    @(posedge clk);
    if (s_flush) begin
      exp_q.delete();
      if (m_out) begin
        if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (resp && !(byp && s_ready)) exp_q.push_back({m_pc, mem_data, EXC_NONE});
      if (e_mis) exp_q.push_back({pc_reg, 32'h0, EXC_ADEL_F});
      if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
      if (e_req && s_gnt) begin m_out = 1'b1; m_pc = pc_reg; end
    end
    if (mem_busy) begin
      if (mem_cnt == 1) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (e_req && s_gnt) begin mem_busy = 1'b1; mem_cnt = s_lat; mem_data = s_data; end
    if (auto_pc && !e_stall) begin
      if (s_flush) pc_reg = s_target;
      else if (rnd_mode && $urandom_range(0, 9) == 0) begin
        tmp = $urandom;
        pc_reg = {tmp[31:2], ($urandom_range(0, 3) == 0) ? tmp[1:0] : 2'b00};
      end else pc_reg = pc_reg + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; d_ready = 1'b0;
    pc = 32'h0000_1000;
    exp_q.delete(); m_out = 1'b0; m_drop = 1'b0; mem_busy = 1'b0;
    s_flush = 1'b0; s_gnt = 1'b0; s_ready = 1'b0; rnd_mode = 1'b0; auto_pc = 1'b1;
    @(negedge clk); #1;
    chk("rst_installF", 32'(installF), 32'd1);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_pc", d_pc, TB_PCBASE);
    chk("rst_d_instr", d_instr, 32'h0);
    chk("rst_d_exc", 32'(d_exc), 32'h0);
    chk("rst_count", 32'(dbg_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
  endtask

  task automatic rand_stim(input int phase);
    logic [31:0] tmp;
    s_gnt = ($urandom_range(0, 3) != 0);
    case (phase)
      0: s_ready = ($urandom_range(0, 3) != 0);
      1: s_ready = ($urandom_range(0, 3) == 0);
      default: s_ready = ($urandom_range(0, 1) == 1);
    endcase
    s_flush = ($urandom_range(0, 24) == 0);
    tmp = $urandom;
    s_target = {tmp[31:2], 2'b00};
    s_lat = $urandom_range(1, 3);
    s_data = $urandom;
  endtask

  initial begin
    // reset-release fetch, one-cycle response
    do_reset();
    pc_reg = 32'hBFC0_0000; s_gnt = 1'b1; s_lat = 1; s_data = 32'h2408_0001; s_ready = 1'b1;
    step();
    chk("A_req", 32'(obs_req), 32'd1);
    chk("A_addr", obs_addr, 32'hBFC0_0000);
    chk("A_stall", 32'(obs_stall), 32'd0);
    s_gnt = 1'b0;
    step();
`ifdef FETCH_BYPASS_EN
    chk("A_byp_dvalid", 32'(obs_dvalid), 32'd1);
    chk("A_byp_dpc", obs_dpc, 32'hBFC0_0000);
    chk("A_byp_instr", obs_dinstr, 32'h2408_0001);
`else
    chk("A_dvalid_early", 32'(obs_dvalid), 32'd0);
    step();
    chk("A_dvalid", 32'(obs_dvalid), 32'd1);
    chk("A_dpc", obs_dpc, 32'hBFC0_0000);
    chk("A_instr", obs_dinstr, 32'h2408_0001);
    chk("A_exc", 32'(obs_exc), 32'h0);
`endif

    // misaligned pc
    do_reset();
    auto_pc = 1'b0; pc_reg = 32'h0040_0002; s_gnt = 1'b1; s_ready = 1'b0;
    step();
    chk("B_req", 32'(obs_req), 32'd0);
    chk("B_stall", 32'(obs_stall), 32'd0);
    pc_reg = 32'h0040_0010; s_gnt = 1'b0;
    step();
    chk("B_stall_next", 32'(obs_stall), 32'd1);
    chk("B_dvalid", 32'(obs_dvalid), 32'd1);
    chk("B_dpc", obs_dpc, 32'h0040_0002);
    chk("B_instr", obs_dinstr, 32'h0);
    chk("B_exc", 32'(obs_exc), 32'h002);

    // fill with decode stalled
    do_reset();
    pc_reg = 32'h0000_1000; s_gnt = 1'b1; s_lat = 1; s_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin s_data = $urandom; step(); end
    chk("C_count", obs_count, 32'd4);
    chk("C_stall", 32'(obs_stall), 32'd1);
    chk("C_req", 32'(obs_req), 32'd0);
    s_ready = 1'b1;
    step();
    chk("C_release", 32'(obs_stall), 32'd0);
    chk("C_head0", obs_dpc, 32'h0000_1000);
    step();
    chk("C_head1", obs_dpc, 32'h0000_1004);

    // flush while waiting; late response dropped
    do_reset();
    pc_reg = 32'h0000_2000; s_gnt = 1'b1; s_lat = 2; s_data = 32'hDEADBEEF; s_ready = 1'b1;
    seen_dead = 1'b0;
    step();
    s_gnt = 1'b0; s_flush = 1'b1; s_target = 32'h0000_3000;
    step();
    chk("D_flush_stall", 32'(obs_stall), 32'd0);
    s_flush = 1'b0; s_gnt = 1'b1; s_lat = 1; s_data = 32'h1111_1111;
    step();
    chk("D_drop_req", 32'(obs_req), 32'd0);
    chk("D_drop_state", obs_state, 32'(ST_DROP));
    step();
    chk("D_req", 32'(obs_req), 32'd1);
    chk("D_addr", obs_addr, 32'h0000_3000);
    chk("D_state", obs_state, 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) step();
    chk("D_no_dead", 32'(seen_dead), 32'd0);

    // flush coincident with a response into a full queue
    do_reset();
    pc_reg = 32'h0000_4000; s_gnt = 1'b1; s_lat = 1; s_ready = 1'b0;
    for (int i = 0; i < 20 && !(exp_q.size() == DEPTH - 1 && mem_busy && mem_cnt == 1); i++) begin
      s_data = $urandom; step();
    end
    s_flush = 1'b1; s_target = 32'h0000_4800;
    step();
    chk("E_stall", 32'(obs_stall), 32'd0);
    chk("E_req", 32'(obs_req), 32'd0);
    chk("E_count_before", obs_count, 32'd3);
    s_flush = 1'b0; s_gnt = 1'b0;
    step();
    chk("E_count", obs_count, 32'd0);
    chk("E_dvalid", 32'(obs_dvalid), 32'd0);

    // empty queue, decode ready
    do_reset();
    pc_reg = 32'h0000_5000; s_gnt = 1'b1; s_lat = 1; s_data = 32'hCAFE_0001; s_ready = 1'b1;
    step();
    s_gnt = 1'b0;
    step();
`ifdef FETCH_BYPASS_EN
    chk("F_dvalid", 32'(obs_dvalid), 32'd1);
    chk("F_instr", obs_dinstr, 32'hCAFE_0001);
    chk("F_pc", obs_dpc, 32'h0000_5000);
    step();
    chk("F_count_after", obs_count, 32'd0);
    chk("F_dvalid_after", 32'(obs_dvalid), 32'd0);
`else
    chk("F_dvalid_early", 32'(obs_dvalid), 32'd0);
    step();
    chk("F_dvalid", 32'(obs_dvalid), 32'd1);
    chk("F_instr", obs_dinstr, 32'hCAFE_0001);
`endif

    // randomized traffic, with resets between chunks (possibly mid-request)
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      rnd_mode = 1'b1; pc_reg = 32'h0001_0000;
      for (int i = 0; i < 1500; i++) begin
        rand_stim(ph);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4; number of instruction-queue entries, a power of 2 and at least 2.
REQ-002 Parameter PCBASE, default `PCBASE; the reset value of the queue pc fields.
REQ-003 clk  input  1  single clock for the block.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pc  input  32  current fetch address from the PC register.
REQ-006 installF  output  1  stall to the PC register; 1 = hold pc, 0 = load npc.
REQ-007 flush  input  1  redirect; discards all queued and in-flight fetches.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address (word aligned).
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  response valid; arrives at least 1 cycle after the grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 d_valid  output  1  queue head valid to decode.
REQ-014 d_ready  input  1  decode accepts the head.
REQ-015 d_pc / d_instr  output  32 each  pc and instruction of the head entry.
REQ-016 d_exc  output  9  exception code of the head; 9'h000 = none, 9'h002 = misaligned fetch.

Function
REQ-017 FSM states: IDLE, WAIT (one request outstanding), DROP (discard one in-flight response); at most 1 outstanding request.
REQ-018 "Space": queue count plus outstanding requests is below DEPTH, counting a pop that occurs in the same cycle.
REQ-019 IDLE, space, pc[1:0]==0, no flush: imem_req=1 and imem_addr=pc; on imem_gnt, latch pc, go to WAIT, installF=0.
REQ-020 IDLE, space, pc[1:0]!=0, no flush: no request; push {pc, 32'h0, 9'h002} this cycle; installF=0.
REQ-021 WAIT, imem_rvalid: push {latched pc, imem_rdata, 9'h000}; if space remains and pc is aligned, issue the next request in the same cycle (back-to-back).
REQ-022 WAIT after the next grant, next state is WAIT; otherwise next state is IDLE.
REQ-023 installF=1 whenever the current pc is not accepted this cycle (no grant, no misaligned push, no space, WAIT without rvalid, DROP).
REQ-024 Queue: FIFO with pop on d_valid&&d_ready; d_valid=(count!=0); push and pop may occur in the same cycle when full.
REQ-025 Flush has priority over everything: count set to 0, no request, no push, installF=0 so the PC register loads the redirect target.
REQ-026 Flush in WAIT without rvalid goes to DROP; flush in WAIT with rvalid goes to IDLE and the response is discarded.
REQ-027 Flush in DROP stays in DROP.
REQ-028 DROP: no requests; the next imem_rvalid is discarded, then the state goes to IDLE.
REQ-029 A push into a full queue without a pop is impossible by REQ-018; it is an assertion failure.

Reset
REQ-030 During rst: state=IDLE, count=0, read/write pointers=0, imem_req=0, d_valid=0.
REQ-031 During rst: installF=1, imem_addr=0, d_pc=PCBASE, d_instr=0, d_exc=9'h000.
REQ-032 Reset asserted mid-request drops the outstanding request; the memory side is reset together with this block.

Configuration
REQ-033 Macro FETCH_BYPASS_EN: when defined, an empty queue in WAIT with imem_rvalid drives that response directly onto d_* in the same cycle (d_valid=1); if d_ready=1 the entry is not pushed.
REQ-034 Without FETCH_BYPASS_EN, every response is pushed and d_valid rises no earlier than 1 cycle after imem_rvalid.

Structure
REQ-035 The shared package holds: FSM state encoding, the 9-bit exception codes EXC_NONE=9'h000 and EXC_ADEL_F=9'h002, and the queue entry struct {pc, instr, exc}.
REQ-036 One sub-module, fetch_fifo (DEPTH-entry synchronous FIFO, async reset, count output); the FSM and stall logic live in the top.

Verification
REQ-037 Reset release, pc=0xBFC00000, gnt=1, rvalid 1 cycle later, data=0x24080001, d_ready=1 -> d_valid with d_pc=0xBFC00000, d_instr=0x24080001, d_exc=0.
REQ-038 pc=0x00400002 -> no imem_req; the entry is pushed with d_exc=9'h002, d_instr=0; installF=0 for 1 cycle.
REQ-039 d_ready=0, continuous 1-cycle responses -> exactly DEPTH=4 entries queued; installF stays 1 until d_ready rises; FIFO order preserved.
REQ-040 flush in WAIT, response 2 cycles later with data 0xDEADBEEF -> 0xDEADBEEF never appears on d_*; state IDLE afterwards; the first request after flush uses the new pc.
REQ-041 flush coincident with imem_rvalid and a full queue -> count=0, installF=0, no push.
REQ-042 FETCH_BYPASS_EN, empty queue, d_ready=1 -> d_valid in the same cycle as imem_rvalid; count remains 0.
